// File: rtl/ipif_axil_pkg.sv
// Shared constants, FSM state types and address decode helper for the IPIF AXI4-Lite slave.
package ipif_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_EXEC = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  // Byte address to register index: drop the byte-lane bits.
  function automatic logic [63:0] reg_index(input logic [63:0] addr, input int unsigned lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/ipif_strobe_reg.sv
// One DW-bit register with byte-enable write and async active-low reset to INIT.
// Ports: clk, rst_n, we_i (write strobe), strb_i (byte enables), d_i (write data), q_o (contents).
module ipif_strobe_reg
  import ipif_axil_pkg::*;
#(
  parameter int unsigned    DW   = 32,
  parameter logic [DW-1:0]  INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [DW/8-1:0]  strb_i,
  input  logic [DW-1:0]    d_i,
  output logic [DW-1:0]    q_o
);

  logic [DW-1:0] q_d, q_q;

  // Merge enabled byte lanes into the held value.
  always_comb begin
    q_d = q_q;
    if (we_i) begin
      for (int b = 0; b < int'(DW / 8); b++) begin
        if (strb_i[b]) q_d[b*8 +: 8] = d_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= INIT;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/ipif_axil_slave.sv
// AXI4-Lite slave front end for the IPIF register path (bus clock domain).
// Ports: AXI4-Lite slave channels AW/W/B/AR/R on S_AXI_ACLK / S_AXI_ARESETN;
//   RdCE/WrCE one-cycle one-hot per-register strobes; params_from_bus register
//   file contents (reg i at [i*DW +: DW]); params_to_bus readback values.
module ipif_axil_slave
  import ipif_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned N_REG              = 2,
  parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] REG_RESET = '0,
  parameter logic [N_REG-1:0]                    RO_MASK   = '0
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [N_REG-1:0]                     RdCE,
  output logic [N_REG-1:0]                     WrCE,
  output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]  params_from_bus,
  input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]  params_to_bus
);

  localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW  = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned LSB = $clog2(SW);

  // Protection bits carry no meaning for this register file.
  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // One-hot register select; all-zero for an out-of-range index.
  function automatic logic [N_REG-1:0] decode(input logic [AW-1:0] a);
    logic [N_REG-1:0] sel;
    sel = '0;
    for (int i = 0; i < int'(N_REG); i++) begin
      sel[i] = (reg_index(64'(a), LSB) == 64'(i));
    end
    return sel;
  endfunction

  // ---------------- write channel ----------------
  wr_state_t        wr_state_q, wr_state_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             aw_got_q, aw_got_d;
  logic             w_got_q, w_got_d;
  logic [AW-1:0]    awaddr_q, awaddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]    wstrb_q, wstrb_d;
  logic [N_REG-1:0] wrce_q, wrce_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             aw_hs, w_hs;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;

  // Write FSM: collect AW and W independently, strobe for one cycle, then respond.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wrce_d     = '0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
        end
        awready_d = ~aw_got_d;
        wready_d  = ~w_got_d;
        if (aw_got_d && w_got_d) begin
          wr_state_d = W_EXEC;
          wrce_d     = decode(awaddr_d) & ~RO_MASK;
        end
      end
      W_EXEC: begin
        // The strobe doubles as the register write enable, so the new value
        // lands on the edge that ends this cycle.
        bresp_d    = (|wrce_q) ? RESP_OKAY : RESP_SLVERR;
        bvalid_d   = 1'b1;
        aw_got_d   = 1'b0;
        w_got_d    = 1'b0;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wrce_q     <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wrce_q     <= wrce_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // ---------------- read channel ----------------
  rd_state_t        rd_state_q, rd_state_d;
  logic             arready_q, arready_d;
  logic [N_REG-1:0] rdce_q, rdce_d;
  logic             rvalid_q, rvalid_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             ar_hs;

  assign ar_hs = S_AXI_ARVALID & arready_q;

  // Read FSM: the latched decode (rdce_q) selects the readback word during R_EXEC.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rdce_d     = '0;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d  = 1'b0;
          rdce_d     = decode(S_AXI_ARADDR);
          rd_state_d = R_EXEC;
        end
      end
      R_EXEC: begin
        rdata_d = '0;
        for (int i = 0; i < int'(N_REG); i++) begin
          if (rdce_q[i]) rdata_d = params_to_bus[i*DW +: DW];
        end
        rresp_d    = (|rdce_q) ? RESP_OKAY : RESP_SLVERR;
        rvalid_d   = 1'b1;
        rd_state_d = R_RESP;
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rdce_q     <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rdce_q     <= rdce_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  // ---------------- register file ----------------
  for (genvar g = 0; g < int'(N_REG); g++) begin : g_reg
    ipif_strobe_reg #(
      .DW   (DW),
      .INIT (REG_RESET[g*DW +: DW])
    ) u_reg (
      .clk    (S_AXI_ACLK),
      .rst_n  (S_AXI_ARESETN),
      .we_i   (wrce_q[g]),
      .strb_i (wstrb_q),
      .d_i    (wdata_q),
      .q_o    (params_from_bus[g*DW +: DW])
    );
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign RdCE          = rdce_q;
  assign WrCE          = wrce_q;

endmodule

// File: tb/tb_ipif_axil_slave.sv
// Directed bench for ipif_axil_slave: 3 registers, register 2 read-only.
`timescale 1ns/1ps
module tb_ipif_axil_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned NR = 3;
  localparam logic [NR-1:0]    RO      = 3'b100;
  localparam logic [NR*DW-1:0] RST_IMG = {32'h0000C0DE, 32'h11112222, 32'h33334444};

  logic clk, rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NR-1:0] rdce, wrce;
  logic [NR*DW-1:0] pfb, ptb_bus;

  logic [DW-1:0] mdl_reg [NR];
  logic [DW-1:0] ptb [NR];
  logic [NR*DW-1:0] mdl_img;
  logic [NR-1:0] exp_wrce = '0;
  logic [NR-1:0] exp_rdce = '0;
  bit cmp_en = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] got;

  assign mdl_img = {mdl_reg[2], mdl_reg[1], mdl_reg[0]};
  assign ptb_bus = {ptb[2], ptb[1], ptb[0]};

  ipif_axil_slave #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .N_REG              (NR),
    .REG_RESET          (RST_IMG),
    .RO_MASK            (RO)
  ) dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rst_n),
    .S_AXI_AWADDR    (awaddr),
    .S_AXI_AWPROT    (awprot),
    .S_AXI_AWVALID   (awvalid),
    .S_AXI_AWREADY   (awready),
    .S_AXI_WDATA     (wdata),
    .S_AXI_WSTRB     (wstrb),
    .S_AXI_WVALID    (wvalid),
    .S_AXI_WREADY    (wready),
    .S_AXI_BRESP     (bresp),
    .S_AXI_BVALID    (bvalid),
    .S_AXI_BREADY    (bready),
    .S_AXI_ARADDR    (araddr),
    .S_AXI_ARPROT    (arprot),
    .S_AXI_ARVALID   (arvalid),
    .S_AXI_ARREADY   (arready),
    .S_AXI_RDATA     (rdata),
    .S_AXI_RRESP     (rresp),
    .S_AXI_RVALID    (rvalid),
    .S_AXI_RREADY    (rready),
    .RdCE            (rdce),
    .WrCE            (wrce),
    .params_from_bus (pfb),
    .params_to_bus   (ptb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no handshake within 50 cycles, expected one", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) mdl_reg[i] = RST_IMG[i*DW +: DW];
  endtask

  // Strobes and register image against the model, every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("wrce", 128'(wrce), 128'(exp_wrce));
      check("rdce", 128'(rdce), 128'(exp_rdce));
      check("regs", 128'(pfb), 128'(mdl_img));
    end
  end

  // b_delay < 0 leaves the response pending (BREADY low) and returns.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, input int b_delay);
    int idx, cyc;
    logic ok, aw_seen, w_seen, hs_aw, hs_w;
    logic [NR-1:0] ce;
    idx = int'(addr >> 2);
    ok = 1'b0;
    if (idx < int'(NR)) ok = !RO[idx];
    ce = '0;
    if (ok) ce[idx] = 1'b1;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; wvalid = 1'b1;
    if (w_lead == 0) awvalid = 1'b1;
    aw_seen = 1'b0; w_seen = 1'b0; cyc = 0;
    while (!(aw_seen && w_seen)) begin
      @(negedge clk);
      if (w_seen && !aw_seen) check("wready_low_after_w", 128'(wready), 128'(0));
      hs_aw = awvalid & awready;
      hs_w  = wvalid & wready;
      @(posedge clk); #1;
      if (hs_aw) begin awvalid = 1'b0; aw_seen = 1'b1; end
      if (hs_w)  begin wvalid = 1'b0;  w_seen = 1'b1;  end
      cyc++;
      if (cyc == w_lead) awvalid = 1'b1;
      if (cyc > 50) begin
        fail_timeout("write_handshake");
        awvalid = 1'b0; wvalid = 1'b0;
        return;
      end
    end
    exp_wrce = ce;
    @(negedge clk);
    check("bvalid_in_exec", 128'(bvalid), 128'(0));
    @(posedge clk); #1;
    exp_wrce = '0;
    if (ok) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mdl_reg[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    @(negedge clk);
    check("bvalid", 128'(bvalid), 128'(1));
    check("bresp", 128'(bresp), ok ? 128'(0) : 128'(2));
    if (b_delay < 0) return;
    repeat (b_delay) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bvalid_hold", 128'(bvalid), 128'(1));
    end
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    check("bvalid_after_b", 128'(bvalid), 128'(0));
    check("awready_after_b", 128'(awready), 128'(1));
    check("wready_after_b", 128'(wready), 128'(1));
  endtask

  // r_delay < 0 leaves the read data pending (RREADY low) and returns.
  task automatic do_read(input logic [7:0] addr, input int r_delay, output logic [31:0] data_o);
    int idx, cyc;
    logic hs;
    logic [NR-1:0] ce;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    idx = int'(addr >> 2);
    ce = '0; exp_d = '0; exp_r = 2'b10;
    if (idx < int'(NR)) begin
      ce[idx] = 1'b1; exp_d = ptb[idx]; exp_r = 2'b00;
    end
    data_o = '0;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs) begin
      @(negedge clk);
      hs = arvalid & arready;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 50) begin
        fail_timeout("read_handshake");
        arvalid = 1'b0;
        return;
      end
    end
    arvalid = 1'b0;
    exp_rdce = ce;
    @(negedge clk);
    check("rvalid_in_exec", 128'(rvalid), 128'(0));
    check("arready_in_exec", 128'(arready), 128'(0));
    @(posedge clk); #1 exp_rdce = '0;
    @(negedge clk);
    check("rvalid", 128'(rvalid), 128'(1));
    check("rdata", 128'(rdata), 128'(exp_d));
    check("rresp", 128'(rresp), 128'(exp_r));
    data_o = rdata;
    if (r_delay < 0) return;
    repeat (r_delay) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rvalid_hold", 128'(rvalid), 128'(1));
      check("rdata_hold", 128'(rdata), 128'(exp_d));
    end
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    check("rvalid_after_r", 128'(rvalid), 128'(0));
    check("arready_after_r", 128'(arready), 128'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = 3'b0; arprot = 3'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    ptb[0] = 32'hA5A50001; ptb[1] = 32'h0F0F7777; ptb[2] = 32'hCAFE0002;
    model_reset();
    cmp_en = 1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_awready", 128'(awready), 128'(0));
    check("rst_wready", 128'(wready), 128'(0));
    check("rst_arready", 128'(arready), 128'(0));
    check("rst_bvalid", 128'(bvalid), 128'(0));
    check("rst_rvalid", 128'(rvalid), 128'(0));
    check("rst_bresp", 128'(bresp), 128'(0));
    check("rst_rresp", 128'(rresp), 128'(0));
    check("rst_rdata", 128'(rdata), 128'(0));
    check("rst_regs_literal", 128'(pfb), 128'(96'h0000C0DE_11112222_33334444));
    #2 rst_n = 1'b1;
    #1 check("awready_before_edge", 128'(awready), 128'(0));
    @(negedge clk);
    check("awready_first_clk", 128'(awready), 128'(1));
    check("wready_first_clk", 128'(wready), 128'(1));
    check("arready_first_clk", 128'(arready), 128'(1));

    // Full-word write, AW and W together.
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 1);
    check("reg1_literal_a", 128'(pfb[63:32]), 128'(32'hDEADBEEF));
    // W leads AW by 3 cycles, low half-word strobe.
    do_write(8'h04, 32'h00001234, 4'b0011, 3, 0);
    check("reg1_literal_b", 128'(pfb[63:32]), 128'(32'hDEAD1234));
    // WSTRB=0: strobe, no change, OKAY.
    do_write(8'h00, 32'hFFFFFFFF, 4'b0000, 0, 0);
    // Low address bits ignored, top byte only.
    do_write(8'h01, 32'hAABBCCDD, 4'b1000, 1, 0);
    check("reg0_literal", 128'(pfb[31:0]), 128'(32'hAA334444));

    // Read with RREADY held off for 5 cycles.
    do_read(8'h00, 5, got);
    check("rdata_literal_a", 128'(got), 128'(32'hA5A50001));

    // Error paths and read-only register.
    do_write(8'h10, 32'h99999999, 4'hF, 0, 0);
    do_write(8'h08, 32'h88888888, 4'hF, 2, 0);
    check("ro_reg_literal", 128'(pfb[95:64]), 128'(32'h0000C0DE));
    do_read(8'h10, 0, got);
    check("oor_rdata_literal", 128'(got), 128'(0));
    do_read(8'h0C, 1, got);
    do_read(8'h08, 0, got);
    check("ro_read_literal", 128'(got), 128'(32'hCAFE0002));

    // Simultaneous read and write of the same register.
    fork
      do_write(8'h04, 32'h5555AAAA, 4'hF, 0, 2);
      begin
        do_read(8'h04, 1, got);
        check("same_reg_read_literal", 128'(got), 128'(32'h0F0F7777));
      end
    join

    // Reset while both channels hold a pending response.
    fork
      do_write(8'h00, 32'h0BADF00D, 4'hF, 0, -1);
      do_read(8'h04, -1, got);
    join
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_bvalid", 128'(bvalid), 128'(0));
    check("async_rvalid", 128'(rvalid), 128'(0));
    check("async_awready", 128'(awready), 128'(0));
    check("async_regs_literal", 128'(pfb), 128'(96'h0000C0DE_11112222_33334444));
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_awready", 128'(awready), 128'(1));
    check("rel_arready", 128'(arready), 128'(1));
    do_write(8'h00, 32'h12345678, 4'hF, 0, 0);
    check("post_reset_literal", 128'(pfb[31:0]), 128'(32'h12345678));
    do_read(8'h04, 0, got);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, expected finish");
    $fatal(1);
  end

endmodule
